mult2c_frac_seq_n: RTL and testbench
====================================

# mult2c_frac_seq_n

Parametrised sequential multiplier for signed two's-complement fractions (Q1.(N-1) × Q1.(N-1)). It uses an add-shift datapath with a final subtract step for the multiplier sign bit. It returns the exact full-width product and an N-bit Q1.(N-1) result with selectable truncate/round and saturation. It is the general-width successor to the fixed 4-bit fractional multiplier in the arithmetic library, and adds operand capture, a busy/done handshake, synchronous reset and the -1 × -1 overflow case.

## Interface
- N, default 8: operand width in bits, Q1.(N-1). Legal range 2..32.
- clk  in  1  rising-edge clock. This is the only clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- rnd  in  1  rounding mode, captured at start. 0 = truncate (floor), 1 = round-half-up.
- mcand  in  N  multiplicand, Q1.(N-1), captured at start.
- mplier  in  N  multiplier, Q1.(N-1), captured at start.
- busy  out  1  high from the accepting edge until the result edge.
- done  out  1  one-cycle pulse; results are valid in this cycle.
- product  out  2N  exact signed product, Q2.(2N-2). Held until the next result.
- y  out  N  rounded/saturated result, Q1.(N-1). Held.
- sat  out  1  high when y was saturated. Held.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - If start=1 on an edge, latch mcand, mplier and rnd into internal registers.
  - Clear the accumulator and step counter. Set busy=1 and go to RUN.
  - Input changes after the accepting edge have no effect on the operation.
- RUN lasts exactly N cycles, one multiplier bit per cycle, LSB first.
  - Steps 0..N-2: if the current multiplier bit is 1, add the sign-extended multiplicand. Then do an arithmetic right shift of {acc, mplier_reg}.
  - Step N-1 (sign bit): if the bit is 1, subtract the multiplicand instead. Then shift.
  - The accumulator is N+1 bits, so no intermediate result overflows. This includes the -1 × -1 case.
  - After step N-1, go to FIN.
- FIN:
  - Register product (2N bits, bit-exact to the mathematical product × 2^(2N-2)).
  - Compute t = product[2N-1:N-1] as an (N+1)-bit signed value.
  - If rnd=1, t = t + product[N-2]. If rnd=0, t is used unchanged (floor).
  - If t > 2^(N-1)-1: y = 0 followed by N-1 ones (max positive), sat=1. Otherwise y = t[N-1:0], sat=0.
  - Only -1 × -1 can saturate. The negative limit is never exceeded.
  - Set done=1, busy=0, go to IDLE.
- start while busy=1 is ignored. Requests are not queued.
- Reset (rst_n=0 at an edge), at any time including mid-RUN or FIN:
  - Go to IDLE and abort the operation; no done is issued.
  - busy=0, done=0, product=0, y=0, sat=0. Internal registers are cleared.
- Reset has priority over start in the same cycle.

## Timing
- Edge k accepts start. RUN steps occupy edges k+1..k+N.
- Edge k+N+1 registers the results and raises done. Latency is N+1 clocks from start to done.
- busy is high in the cycles after edges k..k+N and low from edge k+N+1.
- done is high only in the cycle after edge k+N+1. The FSM is in IDLE in that cycle.
- start=1 during the done cycle is accepted, so back-to-back issue gives one result every N+2 clocks.
- All outputs are registered. There is no combinational path from any input to any output.
- product, y and sat change only at a result edge or at reset.

## Test plan
- N=4, rnd=1, mcand=0101, mplier=1011 (0.625 × -0.625) -> after 5 clocks: done pulse, product=0xE7 (-25/64), y=1101, sat=0. Same operands with rnd=0 -> y=1100.
- N=4, mcand=1000, mplier=1000 (-1 × -1) -> product=0x40, y=0111, sat=1 in both modes. Also check 1000 × 0111 -> product=0xC8, y=1001, sat=0.
- N=8, mcand=mplier=0x7F -> product=0x3F01, y=0x7E, sat=0. Also check 0x00 × 0x80 -> all-zero outputs.
- Handshake: start held high continuously -> done every 10 clocks for N=8. Toggle mcand during RUN -> result unchanged. start pulses while busy -> ignored, and busy stays high for exactly N+1 cycles.
- Reset mid-RUN at step 3 (N=8) -> next cycle busy=0, outputs 0, no done. A new start then gives the correct result with the same latency.
- Exhaustive N=4 (256 pairs × 2 modes) against a reference model -> bit-exact product, y and sat.

Source files
------------

// File: rtl/mult2c_frac_seq_n.sv
// Sequential signed Q1.(N-1) x Q1.(N-1) fractional multiplier: add-shift datapath with a
// final subtract for the multiplier sign bit, exact 2N-bit product plus rounded/saturated Q1 result.
module mult2c_frac_seq_n #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           rnd,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N-1:0]   y,
    output logic           sat
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N+1:0] MAX_POS = {3'b000, {(N-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state, state_nx;
    logic [N:0]     acc;
    logic [N-1:0]   mc_reg, mp_reg;
    logic           rnd_reg;
    logic [CW-1:0]  step;

    logic           last;
    logic [N:0]     mc_ext, sum;
    logic [2*N-1:0] prod_c;
    logic [N+1:0]   t;
    logic           sat_c;
    logic [N-1:0]   y_c;

    always_comb begin
        last   = (step == CW'(N - 1));
        mc_ext = {mc_reg[N-1], mc_reg};
        sum    = acc;
        // The multiplier's top bit carries weight -2^(N-1), so its partial product is subtracted.
        if (mp_reg[0])
            sum = last ? (acc - mc_ext) : (acc + mc_ext);
        prod_c = {acc[N-1:0], mp_reg};
        t      = {prod_c[2*N-1], prod_c[2*N-1:N-1]}
               + {{(N+1){1'b0}}, rnd_reg & prod_c[N-2]};
        sat_c  = ($signed(t) > $signed(MAX_POS));
        y_c    = sat_c ? MAX_POS[N-1:0] : t[N-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mc_reg  <= '0;
            mp_reg  <= '0;
            rnd_reg <= 1'b0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            y       <= '0;
            sat     <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mc_reg  <= mcand;
                    mp_reg  <= mplier;
                    rnd_reg <= rnd;
                    acc     <= '0;
                    step    <= '0;
                    busy    <= 1'b1;
                end
                RUN: begin
                    // Arithmetic right shift of {acc, mp_reg}; consumed multiplier bits fall out the bottom.
                    acc    <= {sum[N], sum[N:1]};
                    mp_reg <= {sum[0], mp_reg[N-1:1]};
                    step   <= step + 1'b1;
                end
                FIN: begin
                    product <= prod_c;
                    y       <= y_c;
                    sat     <= sat_c;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult2c_frac_seq_n.sv
// Scoreboard bench for mult2c_frac_seq_n: one N=4 and one N=8 instance, directed vectors,
// handshake/reset scenarios and an exhaustive N=4 sweep.
module tb_mult2c_frac_seq_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       s4 = 1'b0, r4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, sat4;
    logic [7:0] p4;
    logic [3:0] y4;

    logic        s8 = 1'b0, r8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, sat8;
    logic [15:0] p8;
    logic [7:0]  y8;

    typedef struct packed {
        logic [15:0] p;
        logic [7:0]  y;
        logic        s;
    } exp_t;

    exp_t q4[$], q8[$];
    exp_t e4, e8;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mult2c_frac_seq_n #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .rnd(r4), .mcand(a4), .mplier(b4),
        .busy(busy4), .done(done4), .product(p4), .y(y4), .sat(sat4)
    );

    mult2c_frac_seq_n #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .rnd(r8), .mcand(a8), .mplier(b8),
        .busy(busy8), .done(done8), .product(p8), .y(y8), .sat(sat8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
            else begin
                e4 = q4.pop_front();
                chk("product4", {24'd0, p4}, {16'd0, e4.p});
                chk("y4", {28'd0, y4}, {24'd0, e4.y});
                chk("sat4", {31'd0, sat4}, {31'd0, e4.s});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("product8", {16'd0, p8}, {16'd0, e8.p});
                chk("y8", {24'd0, y8}, {24'd0, e8.y});
                chk("sat8", {31'd0, sat8}, {31'd0, e8.s});
            end
        end
    end

    function automatic void model4(input logic [3:0] a, input logic [3:0] b, input logic r,
                                   output logic [15:0] p, output logic [7:0] yv, output logic s);
        int ai, bi, pi, t;
        ai = $signed(a);
        bi = $signed(b);
        pi = ai * bi;
        p  = {8'd0, pi[7:0]};
        t  = pi >>> 3;
        if (r) t = t + int'(pi[2]);
        if (t > 7) begin yv = 8'h07; s = 1'b1; end
        else begin yv = {4'd0, t[3:0]}; s = 1'b0; end
    endfunction

    // Issue one operation, scramble inputs during RUN, optionally poke start while busy,
    // and check latency and busy width; the monitor checks the result values.
    task automatic issue(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic r,
                         input logic [15:0] ep, input logic [7:0] ey, input logic es, input bit poke);
        int n, cyc, bcnt;
        bit got;
        n = w8 ? 8 : 4;
        @(negedge clk);
        if (w8) begin
            s8 = 1'b1; a8 = a; b8 = b; r8 = r;
            q8.push_back('{p: ep, y: ey, s: es});
        end else begin
            s4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; r4 = r;
            q4.push_back('{p: ep, y: ey, s: es});
        end
        cyc = 0; bcnt = 0; got = 1'b0;
        while (!got && cyc < 3 * n + 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (w8) begin s8 = 1'b0; a8 = ~a; b8 = ~b; r8 = ~r; end
                else begin s4 = 1'b0; a4 = ~a[3:0]; b4 = ~b[3:0]; r4 = ~r; end
            end
            if (poke && cyc == 3) begin
                if (w8) begin s8 = 1'b1; a8 = 8'h55; end else begin s4 = 1'b1; a4 = 4'h6; end
            end
            if (poke && cyc == 4) begin
                if (w8) s8 = 1'b0; else s4 = 1'b0;
            end
            if (w8 ? busy8 : busy4) bcnt++;
            if (w8 ? done8 : done4) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("latency", cyc, n + 2);
            chk("busy_cycles", bcnt, n + 1);
        end
    endtask

    initial begin
        logic [15:0] ep;
        logic [7:0]  ey;
        logic        es;
        int cyc, nd, last, extra;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_done4", {31'd0, done4}, 32'd0);
        chk("rst_out4", {19'd0, p4, y4, sat4}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_out8", {7'd0, p8, y8, sat8}, 32'd0);

        // N=4 hand-computed vectors
        issue(1'b0, 8'h5, 8'hB, 1'b1, 16'hE7, 8'hD, 1'b0, 1'b1);
        issue(1'b0, 8'h5, 8'hB, 1'b0, 16'hE7, 8'hC, 1'b0, 1'b0);
        issue(1'b0, 8'h8, 8'h8, 1'b1, 16'h40, 8'h7, 1'b1, 1'b0);
        issue(1'b0, 8'h8, 8'h8, 1'b0, 16'h40, 8'h7, 1'b1, 1'b1);
        issue(1'b0, 8'h8, 8'h7, 1'b1, 16'hC8, 8'h9, 1'b0, 1'b0);
        issue(1'b0, 8'h3, 8'hD, 1'b1, 16'hF7, 8'hF, 1'b0, 1'b0);
        issue(1'b0, 8'h3, 8'hD, 1'b0, 16'hF7, 8'hE, 1'b0, 1'b0);

        // N=8 hand-computed vectors
        issue(1'b1, 8'h00, 8'h80, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        issue(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000, 8'h7F, 1'b1, 1'b1);
        issue(1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080, 8'h81, 1'b0, 1'b0);
        issue(1'b1, 8'h7F, 8'h7F, 1'b1, 16'h3F01, 8'h7E, 1'b0, 1'b1);

        // start held high: three back-to-back results, one every N+2 clocks
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; r8 = 1'b0;
        repeat (3) q8.push_back('{p: 16'h3F01, y: 8'h7E, s: 1'b0});
        cyc = 0; nd = 0; last = 0;
        while (nd < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                nd++;
                if (nd > 1) chk("b2b_period", cyc - last, 10);
                last = cyc;
                if (nd == 3) s8 = 1'b0;
            end
        end
        chk("b2b_count", nd, 3);

        // reset during RUN aborts the operation and clears the held outputs
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; r8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_product", {16'd0, p8}, 32'd0);
        chk("abort_y_sat", {23'd0, y8, sat8}, 32'd0);
        rst_n = 1'b1;
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8) extra++;
        end
        chk("abort_no_done", extra, 0);
        issue(1'b1, 8'h80, 8'h7F, 1'b0, 16'hC080, 8'h81, 1'b0, 1'b0);

        // exhaustive N=4 against the arithmetic model
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    model4(4'(i), 4'(j), 1'(r), ep, ey, es);
                    issue(1'b0, 8'(i), 8'(j), 1'(r), ep, ey, es, 1'b0);
                end

        repeat (3) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
